// File: rtl/mcu_run_ctrl.sv
// Debug run/step controller: debounced run/step keys, address breakpoint and a
// single-clock enable (mcu_ce) so the MCU core and its glue stay on clk.
module mcu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SLOW_DIV_LOG2   = 23,
  parameter bit          RESET_RUN       = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_run_n,
  input  logic             key_step_n,
  input  logic             slow_en,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      mem_addr,
  input  logic [1:0]       mem_trans,
  output logic             mcu_ce,
  output logic [1:0]       run_state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] ce_count
);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StSlow = 2'b10,
    StStep = 2'b11
  } st_e;

  localparam st_e ResetSt = RESET_RUN ? StRun : StHalt;

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SLOW_DIV_LOG2-1:0] SlowPenult = ~SLOW_DIV_LOG2'(1);

  // Key bit 0 is run, bit 1 is step; all levels kept in raw active-low polarity.
  logic [1:0]          key_raw;
  logic [1:0]          sync1_q, sync2_q, level_q;
  logic [1:0][DbW-1:0] db_cnt_q;
  logic [1:0]          flip, press;

  assign key_raw = {key_step_n, key_run_n};

  always_comb begin
    flip  = '0;
    press = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i]  = (sync2_q[i] != level_q[i]) && (db_cnt_q[i] == DbLast);
      press[i] = flip[i] & ~sync2_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      level_q  <= 2'b11;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (flip[i]) begin
            level_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic [SLOW_DIV_LOG2-1:0] slow_q;
  logic                     tick_next;

  // mcu_ce is registered, so it is computed against the tick one cycle ahead.
  assign tick_next = (slow_q == SlowPenult);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slow_q <= '0;
    end else begin
      slow_q <= slow_q + SLOW_DIV_LOG2'(1);
    end
  end

  st_e  state_q, state_d;
  logic bp_hit_q, bp_hit_d;
  logic mcu_ce_q, mcu_ce_d;
  logic bp_match;
  logic press_run, press_step;

  assign press_run  = press[0];
  assign press_step = press[1];
  assign bp_match   = bp_en & mcu_ce_q & (mem_trans != 2'b00) & (mem_addr == bp_addr);

  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    unique case (state_q)
      StRun, StSlow: begin
        if (bp_match) begin
          state_d  = StHalt;
          bp_hit_d = 1'b1;
        end else if (press_run) begin
          state_d = StHalt;
        end else begin
          state_d = slow_en ? StSlow : StRun;
        end
      end
      StHalt: begin
        if (press_run) begin
          state_d  = slow_en ? StSlow : StRun;
          bp_hit_d = 1'b0;
        end else if (press_step) begin
          state_d = StStep;
        end
      end
      StStep: state_d = StHalt;
      default: state_d = StHalt;
    endcase
    mcu_ce_d = (state_d == StRun) | ((state_d == StSlow) & tick_next) | (state_d == StStep);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ResetSt;
      bp_hit_q <= 1'b0;
      mcu_ce_q <= 1'b0;
      ce_count <= '0;
    end else begin
      state_q  <= state_d;
      bp_hit_q <= bp_hit_d;
      mcu_ce_q <= mcu_ce_d;
      if (mcu_ce_q) begin
        ce_count <= ce_count + CNT_W'(1);
      end
    end
  end

  assign mcu_ce    = mcu_ce_q;
  assign run_state = state_q;
  assign halted    = (state_q == StHalt);
  assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_mcu_run_ctrl.sv
// Directed bench for mcu_run_ctrl: reset, key debounce, step, breakpoint and slow mode.
module tb_mcu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_run_n, key_step_n, slow_en, bp_en;
  logic [31:0] bp_addr, mem_addr;
  logic [1:0]  mem_trans;
  logic        mcu_ce, halted, bp_hit;
  logic [1:0]  run_state;
  logic [15:0] ce_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mcu_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_DIV_LOG2  (3),
    .RESET_RUN      (1'b1),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_run_n (key_run_n),
    .key_step_n(key_step_n),
    .slow_en   (slow_en),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .mem_addr  (mem_addr),
    .mem_trans (mem_trans),
    .mcu_ce    (mcu_ce),
    .run_state (run_state),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .ce_count  (ce_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pos[$];
    int ones;
    int g1, g2;

    reset_n    = 1'b0;
    key_run_n  = 1'b1;
    key_step_n = 1'b1;
    slow_en    = 1'b0;
    bp_en      = 1'b0;
    bp_addr    = 32'h0;
    mem_addr   = 32'h0;
    mem_trans  = 2'b00;

    // Reset state and RUN after reset
    step(3);
    check("rst_state", run_state, 2'b01);
    check("rst_ce", mcu_ce, 1'b0);
    check("rst_cnt", ce_count, 16'd0);
    check("rst_bphit", bp_hit, 1'b0);
    check("rst_halted", halted, 1'b0);
    reset_n = 1'b1;
    step(1);
    check("run_ce_first", mcu_ce, 1'b1);
    check("run_cnt_first", ce_count, 16'd0);
    step(10);
    check("run_cnt_10", ce_count, 16'd10);
    check("run_ce_10", mcu_ce, 1'b1);

    // Bouncing run key while running: one press, halt
    key_run_n = 1'b0;
    step(2);
    key_run_n = 1'b1;
    step(1);
    key_run_n = 1'b0;
    step(5);
    check("bounce_not_yet", halted, 1'b0);
    check("bounce_state_run", run_state, 2'b01);
    step(1);
    check("bounce_halted", halted, 1'b1);
    check("bounce_state", run_state, 2'b00);
    check("bounce_ce", mcu_ce, 1'b0);
    check("bounce_cnt", ce_count, 16'd19);
    step(4);
    key_run_n = 1'b1;
    step(10);
    check("release_halted", halted, 1'b1);
    check("release_cnt", ce_count, 16'd19);

    // Three single steps, holding the key gives no extra pulse
    for (int i = 0; i < 3; i++) begin
      key_step_n = 1'b0;
      step(5);
      check("step_pre_state", run_state, 2'b00);
      check("step_pre_ce", mcu_ce, 1'b0);
      step(1);
      check("step_state", run_state, 2'b11);
      check("step_ce", mcu_ce, 1'b1);
      step(1);
      check("step_post_state", run_state, 2'b00);
      check("step_post_ce", mcu_ce, 1'b0);
      check("step_cnt", ce_count, 16'(20 + i));
      step(8);
      check("step_hold_cnt", ce_count, 16'(20 + i));
      check("step_hold_halted", halted, 1'b1);
      key_step_n = 1'b1;
      step(10);
    end

    // Resume RUN, then breakpoint
    key_run_n = 1'b0;
    step(6);
    check("resume_state", run_state, 2'b01);
    check("resume_ce", mcu_ce, 1'b1);
    check("resume_cnt", ce_count, 16'd22);
    key_run_n = 1'b1;
    step(10);
    check("run_cnt_32", ce_count, 16'd32);
    bp_en    = 1'b1;
    bp_addr  = 32'h0000_0040;
    mem_addr = 32'h0000_0040;
    step(3);
    check("bp_idle_state", run_state, 2'b01);
    check("bp_idle_bphit", bp_hit, 1'b0);
    check("bp_idle_cnt", ce_count, 16'd35);
    mem_trans = 2'b10;
    step(1);
    mem_trans = 2'b00;
    check("bp_state", run_state, 2'b00);
    check("bp_hit", bp_hit, 1'b1);
    check("bp_ce", mcu_ce, 1'b0);
    check("bp_cnt", ce_count, 16'd36);
    check("bp_halted", halted, 1'b1);

    // Press run from HALT clears bp_hit
    key_run_n = 1'b0;
    step(6);
    check("rerun_state", run_state, 2'b01);
    check("rerun_bphit", bp_hit, 1'b0);
    key_run_n = 1'b1;
    step(10);

    // Same-cycle breakpoint and run press
    key_run_n = 1'b0;
    step(5);
    mem_trans = 2'b10;
    step(1);
    mem_trans = 2'b00;
    check("both_state", run_state, 2'b00);
    check("both_bphit", bp_hit, 1'b1);
    check("both_ce", mcu_ce, 1'b0);
    key_run_n = 1'b1;
    step(10);
    check("both_hold_state", run_state, 2'b00);
    key_run_n = 1'b0;
    step(6);
    check("both_rerun_state", run_state, 2'b01);
    check("both_rerun_bphit", bp_hit, 1'b0);
    key_run_n = 1'b1;
    step(10);

    // SLOW: one pulse every 8 cycles
    slow_en = 1'b1;
    step(1);
    check("slow_state", run_state, 2'b10);
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (mcu_ce) pos.push_back(i);
    end
    g1 = (pos.size() >= 2) ? pos[1] - pos[0] : 0;
    g2 = (pos.size() >= 3) ? pos[2] - pos[1] : 0;
    check("slow_pulses", pos.size(), 3);
    check("slow_gap1", g1, 8);
    check("slow_gap2", g2, 8);
    check("slow_state_hold", run_state, 2'b10);
    slow_en = 1'b0;
    step(1);
    check("slow_to_run", run_state, 2'b01);
    check("slow_to_run_ce", mcu_ce, 1'b1);
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (mcu_ce) ones++;
    end
    check("run_cont_ce", ones, 5);

    // Asynchronous reset mid-run
    reset_n = 1'b0;
    #1;
    check("arst_ce", mcu_ce, 1'b0);
    check("arst_cnt", ce_count, 16'd0);
    check("arst_state", run_state, 2'b01);
    check("arst_bphit", bp_hit, 1'b0);
    step(2);
    check("arst_hold_ce", mcu_ce, 1'b0);
    reset_n = 1'b1;
    step(1);
    check("arst_rel_ce", mcu_ce, 1'b1);
    step(1);
    check("arst_rel_cnt", ce_count, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
